// File: rtl/boot_pkg.sv
// -----------------------------------------------------------------------------
// boot_pkg
// Shared definitions for the boot copy path. The boot loader, the boot ROM and
// the SoC top all import these.
//   BOOT_DW        : data word width of the boot ROM and memory write port
//   BOOT_ROM_WORDS : default number of ROM words copied at boot
//   BOOT_WAIT_MAX  : default write-acknowledge timeout, in clock cycles
//   boot_state_e   : boot loader sequencer states
// -----------------------------------------------------------------------------
package boot_pkg;

    localparam int unsigned BOOT_DW        = 16;
    localparam int unsigned BOOT_ROM_WORDS = 8;
    localparam int unsigned BOOT_WAIT_MAX  = 15;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } boot_state_e;

endpackage : boot_pkg

// File: rtl/boot_wait_timer.sv
// -----------------------------------------------------------------------------
// boot_wait_timer
// Wait-state counter with a terminal flag. Counts enabled cycles since the last
// clear; 'expire' is asserted during the enabled cycle that brings the count to
// WAIT_MAX, so the owner can leave its wait state on that same edge.
// Ports:
//   clk    in  clock
//   rst    in  asynchronous, active-high reset (count -> 0)
//   clr    in  synchronous clear, dominates en
//   en     in  count this cycle
//   expire out this enabled cycle is wait number WAIT_MAX
// -----------------------------------------------------------------------------
module boot_wait_timer
    import boot_pkg::*;
#(
    parameter int unsigned WAIT_MAX = BOOT_WAIT_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned CW   = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam int unsigned LAST = (WAIT_MAX == 0) ? 0 : WAIT_MAX - 1;
    localparam int unsigned TOP  = (WAIT_MAX == 0) ? 0 : WAIT_MAX;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != CW'(TOP))) begin
            // Saturates at WAIT_MAX so a caller that keeps 'en' high cannot wrap.
            count_d = count_q + 1'b1;
        end
    end

    assign expire = en && !clr && (count_q == CW'(LAST));

endmodule : boot_wait_timer

// File: rtl/boot_loader.sv
// -----------------------------------------------------------------------------
// boot_loader
// Bus initiator that copies ROM_WORDS words of the boot ROM into main memory
// starting at MEM_BASE, holding the CPU in reset until the copy completes and
// accumulating a modulo-2^16 checksum of the copied words. A write that is not
// acknowledged within WAIT_MAX cycles aborts the copy into an error state.
// Ports:
//   romclk    in  clock
//   rst       in  asynchronous, active-high reset
//   start     in  single-cycle request to (re)run the copy from IDLE/DONE/ERR
//   rom_cs    out ROM chip select (read cycle)
//   rom_we    out ROM write enable, always 0
//   rom_addr  out ROM word address
//   rom_dout  in  ROM read data, captured at the end of the read cycle
//   mem_cs    out memory chip select (write cycle)
//   mem_we    out memory write enable
//   mem_addr  out memory word address (MEM_BASE + index, wraps)
//   mem_din   out memory write data
//   mem_ready in  memory accepted the write this cycle
//   busy      out copy in progress
//   done      out copy completed
//   err       out write timeout occurred
//   cpu_hold  out hold the CPU in reset
//   checksum  out modulo-2^16 sum of the words copied so far
// -----------------------------------------------------------------------------
module boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned ROM_AW     = 3,
    parameter int unsigned ROM_WORDS  = BOOT_ROM_WORDS,
    parameter int unsigned MEM_AW     = 12,
    parameter int unsigned MEM_BASE   = 0,
    parameter bit          AUTO_START = 1'b1,
    parameter int unsigned WAIT_MAX   = BOOT_WAIT_MAX
) (
    input  logic                romclk,
    input  logic                rst,
    input  logic                start,
    output logic                rom_cs,
    output logic                rom_we,
    output logic [ROM_AW-1:0]   rom_addr,
    input  logic [BOOT_DW-1:0]  rom_dout,
    output logic                mem_cs,
    output logic                mem_we,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [BOOT_DW-1:0]  mem_din,
    input  logic                mem_ready,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                cpu_hold,
    output logic [BOOT_DW-1:0]  checksum
);

    localparam logic [MEM_AW-1:0] BASE     = MEM_AW'(MEM_BASE);
    localparam logic [ROM_AW-1:0] LAST_IDX = ROM_AW'(ROM_WORDS - 1);

    boot_state_e          state_q, state_d;
    logic [ROM_AW-1:0]    idx_q, idx_d;
    logic [BOOT_DW-1:0]   data_q, data_d;
    logic [BOOT_DW-1:0]   checksum_q, checksum_d;

    logic                 in_wr;
    logic                 wait_expire;

    // -------------------------------------------------------------------------
    // Write-acknowledge timeout
    // -------------------------------------------------------------------------
    assign in_wr = (state_q == WR);

    boot_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk    (romclk),
        .rst    (rst),
        .clr    (!in_wr || mem_ready),
        .en     (in_wr && !mem_ready),
        .expire (wait_expire)
    );

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge romclk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            data_q     <= '0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            checksum_q <= checksum_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        data_d     = data_q;
        checksum_d = checksum_q;

        unique case (state_q)
            IDLE: begin
                if (AUTO_START || start) begin
                    state_d    = RD;
                    idx_d      = '0;
                    checksum_d = '0;
                end
            end

            RD: begin
                data_d  = rom_dout;
                state_d = WR;
            end

            WR: begin
                // An acknowledge on the last allowed wait cycle still completes
                // the write; the timeout only applies while mem_ready is low.
                if (mem_ready) begin
                    checksum_d = checksum_q + data_q;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = RD;
                    end
                end else if (wait_expire) begin
                    state_d = ERR;
                end
            end

            DONE, ERR: begin
                if (start) begin
                    state_d    = RD;
                    idx_d      = '0;
                    checksum_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode: state plus registers only, so no input reaches an output
    // combinationally. Addresses and data are zero outside their own cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        rom_cs   = 1'b0;
        rom_addr = '0;
        mem_cs   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        cpu_hold = 1'b1;

        unique case (state_q)
            RD: begin
                rom_cs   = 1'b1;
                rom_addr = idx_q;
                busy     = 1'b1;
            end
            WR: begin
                mem_cs   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = BASE + MEM_AW'(idx_q);
                mem_din  = data_q;
                busy     = 1'b1;
            end
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            ERR: begin
                err      = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign rom_we   = 1'b0;
    assign checksum = checksum_q;

endmodule : boot_loader

// File: tb/tb_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_boot_loader
// Self-checking bench for boot_loader. A behavioural ROM and a write-log memory
// surround the DUT; the expected cycle count, write list, checksum and final
// status of each copy are computed from the ROM image and the planned number
// of wait cycles per word.
// -----------------------------------------------------------------------------
module tb_boot_loader;
    import boot_pkg::*;

    localparam int unsigned ROM_AW   = 3;
    localparam int          NW       = 8;
    localparam int unsigned MEM_AW   = 12;
    localparam int unsigned MEM_BASE = 'hFFC;
    localparam int          WMAX     = 15;
    localparam int          BUDGET   = 400;

    logic                romclk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic                mem_ready = 1'b0;
    logic                rom_cs, rom_we, mem_cs, mem_we;
    logic                busy, done, err, cpu_hold;
    logic [ROM_AW-1:0]   rom_addr;
    logic [15:0]         rom_dout;
    logic [MEM_AW-1:0]   mem_addr;
    logic [15:0]         mem_din;
    logic [15:0]         checksum;

    logic [15:0]         rom_img [NW];
    int                  waits   [NW];

    int                  checks   = 0;
    int                  failures = 0;

    // Reference-model results for the current copy
    int                  exp_edges;
    bit                  exp_err;
    int                  exp_nwr;
    logic [15:0]         exp_sum;

    logic [MEM_AW-1:0]   got_addr [$];
    logic [15:0]         got_data [$];

    always #5 romclk = ~romclk;

    assign rom_dout = rom_cs ? rom_img[rom_addr] : 16'hDEAD;

    boot_loader #(
        .ROM_AW     (ROM_AW),
        .ROM_WORDS  (NW),
        .MEM_AW     (MEM_AW),
        .MEM_BASE   (MEM_BASE),
        .AUTO_START (1'b1),
        .WAIT_MAX   (WMAX)
    ) dut (
        .romclk    (romclk),
        .rst       (rst),
        .start     (start),
        .rom_cs    (rom_cs),
        .rom_we    (rom_we),
        .rom_addr  (rom_addr),
        .rom_dout  (rom_dout),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_ready (mem_ready),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cpu_hold  (cpu_hold),
        .checksum  (checksum)
    );

    always @(negedge romclk) begin
        assert (!(rom_cs && mem_cs)) else $error("rom_cs and mem_cs high together");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected outcome of one copy from the ROM image and wait plan:
    // each word costs a read cycle plus (waits+1) write cycles; a word whose
    // plan reaches WMAX waits ends in ERR after WMAX write cycles.
    task automatic model_predict();
        exp_edges = 1;
        exp_err   = 1'b0;
        exp_nwr   = 0;
        exp_sum   = 16'h0000;
        for (int i = 0; i < NW; i++) begin
            if (waits[i] >= WMAX) begin
                exp_edges += 1 + WMAX;
                exp_err    = 1'b1;
                break;
            end
            exp_edges += 2 + waits[i];
            exp_sum   += rom_img[i];
            exp_nwr++;
        end
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_rom_cs"},   rom_cs,   0);
        check_eq({tag, "_rom_we"},   rom_we,   0);
        check_eq({tag, "_rom_addr"}, rom_addr, 0);
        check_eq({tag, "_mem_cs"},   mem_cs,   0);
        check_eq({tag, "_mem_we"},   mem_we,   0);
        check_eq({tag, "_mem_addr"}, mem_addr, 0);
        check_eq({tag, "_mem_din"},  mem_din,  0);
        check_eq({tag, "_busy"},     busy,     0);
        check_eq({tag, "_done"},     done,     0);
        check_eq({tag, "_err"},      err,      0);
        check_eq({tag, "_cpu_hold"}, cpu_hold, 1);
        check_eq({tag, "_checksum"}, checksum, 0);
    endtask

    // Called at a negedge where the next posedge starts the copy (reset just
    // released, or start already raised). Acts as the memory responder and
    // returns at the negedge where done/err is seen, or where word abort_word
    // is being written.
    task automatic run_copy(input string tag, input bit poke, input bit start_on_last,
                            input int abort_word, output bit aborted);
        int edges = 0;
        int word  = 0;
        int stall = 0;
        int wi;
        bit fin   = 1'b0;
        got_addr.delete();
        got_data.delete();
        aborted = 1'b0;
        model_predict();
        while (!fin && edges < BUDGET) begin
            @(posedge romclk);
            edges++;
            @(negedge romclk);
            start = 1'b0;
            check_eq({tag, "_overlap"}, rom_cs & mem_cs, 0);
            check_eq({tag, "_we_only_wr"}, mem_we, mem_cs);
            check_eq({tag, "_rom_we"}, rom_we, 0);
            if (edges == 1) begin
                check_eq({tag, "_first_rom_cs"}, rom_cs, 1);
                check_eq({tag, "_first_busy"}, busy, 1);
                check_eq({tag, "_first_hold"}, cpu_hold, 1);
                check_eq({tag, "_first_done"}, done, 0);
                check_eq({tag, "_first_err"}, err, 0);
                check_eq({tag, "_first_sum"}, checksum, 0);
            end
            wi = (word < NW) ? word : NW - 1;
            if (done || err) begin
                fin = 1'b1;
            end else if (abort_word == word && mem_cs) begin
                aborted = 1'b1;
                fin     = 1'b1;
            end else begin
                if (rom_cs)
                    check_eq({tag, "_rom_addr"}, rom_addr, wi);
                if (mem_cs) begin
                    check_eq({tag, "_mem_addr"}, mem_addr, (MEM_BASE + wi) % 4096);
                    check_eq({tag, "_mem_din"}, mem_din, rom_img[wi]);
                    mem_ready = (stall >= waits[wi]);
                    if (mem_ready) begin
                        got_addr.push_back(mem_addr);
                        got_data.push_back(mem_din);
                        if (start_on_last && word == NW - 1)
                            start = 1'b1;
                        word++;
                        stall = 0;
                    end else begin
                        stall++;
                    end
                end else begin
                    mem_ready = 1'($urandom_range(0, 1));
                end
                if (poke && $urandom_range(0, 3) == 0)
                    start = 1'b1;
            end
        end
        check_eq({tag, "_timeout"}, fin, 1);
        if (fin && !aborted) begin
            check_eq({tag, "_edges"}, edges, exp_edges);
            check_eq({tag, "_done"}, done, !exp_err);
            check_eq({tag, "_err"}, err, exp_err);
            check_eq({tag, "_cpu_hold"}, cpu_hold, exp_err);
            check_eq({tag, "_busy"}, busy, 0);
            check_eq({tag, "_checksum"}, checksum, exp_sum);
            check_eq({tag, "_nwrites"}, got_addr.size(), exp_nwr);
            for (int i = 0; i < got_addr.size() && i < exp_nwr; i++) begin
                check_eq({tag, "_wr_addr"}, got_addr[i], (MEM_BASE + i) % 4096);
                check_eq({tag, "_wr_data"}, got_data[i], rom_img[i]);
            end
        end
    endtask

    // With start low, DONE/ERR must hold with no further bus activity.
    task automatic hold_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            @(posedge romclk);
            @(negedge romclk);
            check_eq({tag, "_rom_cs"}, rom_cs, 0);
            check_eq({tag, "_mem_cs"}, mem_cs, 0);
            check_eq({tag, "_busy"}, busy, 0);
            check_eq({tag, "_done"}, done, !exp_err);
            check_eq({tag, "_err"}, err, exp_err);
            check_eq({tag, "_cpu_hold"}, cpu_hold, exp_err);
            check_eq({tag, "_checksum"}, checksum, exp_sum);
        end
    endtask

    task automatic load_directed();
        rom_img[0] = 16'hF200; rom_img[1] = 16'h4000;
        rom_img[2] = 16'hF800; rom_img[3] = 16'h1007;
        rom_img[4] = 16'hF400; rom_img[5] = 16'h3008;
        rom_img[6] = 16'h4000; rom_img[7] = 16'h0000;
        for (int i = 0; i < NW; i++) waits[i] = 0;
    endtask

    initial begin
        bit ab;
        load_directed();

        // Reset held across several edges
        #1 rst = 1'b1;
        repeat (3) @(posedge romclk);
        @(negedge romclk);
        check_reset("reset");

        // Auto boot, no wait states: 17 edges, checksum 9E0F, writes wrap FFC..003
        rst = 1'b0;
        run_copy("auto", 1'b0, 1'b0, -1, ab);
        check_eq("auto_sum_const", checksum, 16'h9E0F);
        hold_check("auto_hold", 3);

        // Three wait states on word 2, restart from DONE, start pokes while busy
        waits[2] = 3;
        start = 1'b1;
        run_copy("stall", 1'b1, 1'b0, -1, ab);
        check_eq("stall_sum_const", checksum, 16'h9E0F);
        hold_check("stall_hold", 2);

        // Write never acknowledged on word 0 -> ERR, then recovery by start
        waits[2] = 0;
        waits[0] = 20;
        start = 1'b1;
        run_copy("stuck", 1'b0, 1'b0, -1, ab);
        hold_check("stuck_hold", 4);
        waits[0] = 0;
        start = 1'b1;
        run_copy("recover", 1'b0, 1'b1, -1, ab);
        hold_check("recover_hold", 3);

        // Reset during the write of word 4, then auto restart from index 0
        start = 1'b1;
        run_copy("abort", 1'b0, 1'b0, 4, ab);
        check_eq("abort_reached", ab, 1);
        #2 rst = 1'b1;
        #1 check_reset("midrst");
        @(negedge romclk);
        rst = 1'b0;
        run_copy("reboot", 1'b0, 1'b0, -1, ab);
        check_eq("reboot_sum_const", checksum, 16'h9E0F);
        hold_check("reboot_hold", 2);

        // Randomised images and wait plans
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < NW; i++) begin
                rom_img[i] = 16'($urandom);
                waits[i]   = $urandom_range(0, 3);
            end
            if ($urandom_range(0, 3) == 0)
                waits[$urandom_range(0, NW - 1)] = $urandom_range(WMAX, WMAX + 3);
            start = 1'b1;
            run_copy("rand", 1'(t % 2), 1'($urandom_range(0, 1)), -1, ab);
            hold_check("rand_hold", 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_boot_loader
